// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops plus
// iterative unsigned multiply/divide writing HI/LO registers.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    state_t state, state_n;

    // opa: multiplicand or divisor; opb: multiplier or dividend/quotient
    logic [WIDTH-1:0]   opa, opa_n;
    logic [WIDTH-1:0]   opb, opb_n;
    logic [2*WIDTH-1:0] acc, acc_n;
    logic [WIDTH:0]     rem, rem_n;
    logic [CW-1:0]      count, count_n;

    logic [WIDTH-1:0] out_n, hi_n, lo_n;
    logic             zero_n, done_n;

    logic [WIDTH-1:0]   alu_res;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     div_shift, div_diff;

    assign busy = (state != IDLE);

    // single-cycle result for the opcode on the inputs
    always_comb begin
        alu_res = '0;
        case (operation)
            OP_AND:  alu_res = in1 & in2;
            OP_OR:   alu_res = in1 | in2;
            OP_ADD:  alu_res = in1 + in2;
            OP_SUB:  alu_res = in1 - in2;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                                ($signed(in1) < $signed(in2))};
            OP_NOR:  alu_res = ~(in1 | in2);
            default: alu_res = '0;
        endcase
    end

    // one MSB-first shift-add step and one restoring-divide step
    always_comb begin
        mul_step  = (acc << 1)
                  + {{WIDTH{1'b0}}, (opb[WIDTH-1] ? opa : {WIDTH{1'b0}})};
        div_shift = (rem << 1) | {{WIDTH{1'b0}}, opb[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opa};
    end

    // next-state and datapath updates
    always_comb begin
        state_n = state;
        opa_n   = opa;
        opb_n   = opb;
        acc_n   = acc;
        rem_n   = rem;
        count_n = count;
        out_n   = out;
        zero_n  = zero;
        hi_n    = hi;
        lo_n    = lo;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (operation == OP_MULTU) begin
                        opa_n   = in1;
                        opb_n   = in2;
                        acc_n   = '0;
                        count_n = CW'(WIDTH);
                        state_n = MUL;
                    end else if (operation == OP_DIVU) begin
                        opa_n   = in2;
                        opb_n   = in1;
                        rem_n   = '0;
                        count_n = CW'(WIDTH);
                        state_n = DIV;
                    end else begin
                        out_n  = alu_res;
                        zero_n = (alu_res == '0);
                        done_n = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_n   = mul_step;
                opb_n   = opb << 1;
                count_n = count - CW'(1);
                if (count == CW'(1)) begin
                    hi_n    = acc_n[2*WIDTH-1:WIDTH];
                    lo_n    = acc_n[WIDTH-1:0];
                    out_n   = acc_n[WIDTH-1:0];
                    zero_n  = (acc_n[WIDTH-1:0] == '0);
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            DIV: begin
                if (!div_diff[WIDTH]) begin
                    rem_n = div_diff;
                    opb_n = {opb[WIDTH-2:0], 1'b1};
                end else begin
                    rem_n = div_shift;
                    opb_n = {opb[WIDTH-2:0], 1'b0};
                end
                count_n = count - CW'(1);
                if (count == CW'(1)) begin
                    hi_n    = rem_n[WIDTH-1:0];
                    lo_n    = opb_n;
                    out_n   = opb_n;
                    zero_n  = (opb_n == '0);
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // datapath and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            rem   <= '0;
            count <= '0;
            out   <= '0;
            zero  <= 1'b1;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            opa   <= opa_n;
            opb   <= opb_n;
            acc   <= acc_n;
            rem   <= rem_n;
            count <= count_n;
            out   <= out_n;
            zero  <= zero_n;
            hi    <= hi_n;
            lo    <= lo_n;
            done  <= done_n;
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized bench for alu_multicycle against an arithmetic
// reference model; covers WIDTH=32 and WIDTH=8 instances.
module tb_alu_multicycle;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic [3:0]  operation;
    logic [31:0] in1, in2;
    logic [31:0] out, hi, lo;
    logic        zero, busy, done;

    logic        start8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8;
    logic [7:0]  out8, hi8, lo8;
    logic        zero8, busy8, done8;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    alu_multicycle #(.WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .operation(operation), .in1(in1), .in2(in2),
        .out(out), .zero(zero), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    alu_multicycle #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8),
        .operation(op8), .in1(a8), .in2(b8),
        .out(out8), .zero(zero8), .busy(busy8), .done(done8),
        .hi(hi8), .lo(lo8)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference: plain arithmetic on the opcode rules
    task automatic model(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] eo,
                         output int lat);
        logic [63:0] p;
        lat = 0;
        case (op)
            OP_AND: eo = a & b;
            OP_OR:  eo = a | b;
            OP_ADD: eo = a + b;
            OP_SUB: eo = a - b;
            OP_SLT: eo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_NOR: eo = ~(a | b);
            OP_MULTU: begin
                p = 64'(a) * 64'(b);
                m_hi = p[63:32];
                m_lo = p[31:0];
                eo = m_lo;
                lat = 32;
            end
            OP_DIVU: begin
                if (b == 0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
                eo = m_lo;
                lat = 32;
            end
            default: eo = '0;
        endcase
    endtask

    task automatic run32(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int inj);
        logic [31:0] eo;
        int elat;
        int nbusy;
        int guard;
        model(op, a, b, eo, elat);
        @(negedge clk);
        start = 1'b1; operation = op; in1 = a; in2 = b;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0;
        guard = 0;
        while (!done && guard < 100) begin
            if (busy) nbusy++;
            if (guard == inj) begin
                start = 1'b1; operation = OP_ADD; in1 = 1; in2 = 2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        check($sformatf("op%0h_done", op), done, 1);
        check($sformatf("op%0h_lat", op), nbusy, elat);
        check($sformatf("op%0h_out", op), out, eo);
        check($sformatf("op%0h_zero", op), zero, eo == 0);
        check($sformatf("op%0h_hi", op), hi, m_hi);
        check($sformatf("op%0h_lo", op), lo, m_lo);
        @(negedge clk);
        check($sformatf("op%0h_pulse", op), done, 0);
        check($sformatf("op%0h_idle", op), busy, 0);
    endtask

    task automatic run8(input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b);
        logic [15:0] p;
        logic [7:0] ehi, elo;
        int nbusy;
        int guard;
        if (op == OP_MULTU) begin
            p = 16'(a) * 16'(b);
            ehi = p[15:8];
            elo = p[7:0];
        end else if (b == 0) begin
            ehi = a;
            elo = 8'hFF;
        end else begin
            ehi = a % b;
            elo = a / b;
        end
        @(negedge clk);
        start8 = 1'b1; op8 = op; a8 = a; b8 = b;
        @(negedge clk);
        start8 = 1'b0;
        nbusy = 0;
        guard = 0;
        while (!done8 && guard < 40) begin
            if (busy8) nbusy++;
            @(negedge clk);
            guard++;
        end
        check("w8_done", done8, 1);
        check("w8_lat", nbusy, 8);
        check("w8_hi", hi8, ehi);
        check("w8_lo", lo8, elo);
        check("w8_out", out8, elo);
        check("w8_zero", zero8, elo == 0);
    endtask

    initial begin
        logic [3:0] ops [9];
        logic [3:0] op;
        logic [31:0] a, b;
        int nd;
        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR,
                OP_MULTU, OP_DIVU, 4'b0011};
        reset = 1'b1;
        start = 1'b0; operation = '0; in1 = '0; in2 = '0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out", out, 0);
        check("rst_zero", zero, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        reset = 1'b0;

        // back-to-back single-cycle ops
        @(negedge clk);
        start = 1'b1; operation = OP_ADD; in1 = 10; in2 = 5;
        @(negedge clk);
        check("b2b_add_out", out, 15);
        check("b2b_add_zero", zero, 0);
        check("b2b_add_done", done, 1);
        operation = OP_SUB; in1 = 5; in2 = 5;
        @(negedge clk);
        start = 1'b0;
        check("b2b_sub_out", out, 0);
        check("b2b_sub_zero", zero, 1);
        check("b2b_sub_done", done, 1);
        @(negedge clk);
        check("b2b_pulse", done, 0);

        run32(OP_SLT, 32'hFFFF_FFFF, 32'd1, -1);
        check("slt_neg", out, 1);
        run32(OP_NOR, 32'd0, 32'd0, -1);
        check("nor_ones", out, 32'hFFFF_FFFF);
        run32(4'b0011, 32'd7, 32'd9, -1);
        check("bad_op_zero", zero, 1);
        run32(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 15);
        check("mul_max_hi", hi, 32'hFFFF_FFFE);
        check("mul_max_lo", lo, 32'h0000_0001);
        run32(OP_DIVU, 32'd100, 32'd7, -1);
        check("div_q", lo, 14);
        check("div_r", hi, 2);
        run32(OP_DIVU, 32'd9, 32'd0, -1);
        check("div0_lo", lo, 32'hFFFF_FFFF);
        check("div0_hi", hi, 9);

        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 7) == 0) op = 4'($urandom);
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            if (op == OP_DIVU && $urandom_range(0, 4) == 0) b = 0;
            if (op == OP_SUB && $urandom_range(0, 3) == 0) b = a;
            run32(op, a, b, -1);
        end

        // abort a multiply with reset at busy cycle 10
        @(negedge clk);
        start = 1'b1; operation = OP_MULTU;
        in1 = $urandom | 32'h1; in2 = $urandom | 32'h1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_pre", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_out", out, 0);
        check("abort_zero", zero, 1);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("abort_no_done", nd, 0);

        run8(OP_MULTU, 8'd200, 8'd3);
        check("w8_mul_hi", hi8, 8'h02);
        check("w8_mul_lo", lo8, 8'h58);
        for (int i = 0; i < 8; i++) begin
            run8(($urandom_range(0, 1) == 0) ? OP_MULTU : OP_DIVU,
                 8'($urandom), 8'($urandom_range(0, 20)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised successor to the CPU's combinational ALU. It executes the six base operations (AND, OR, ADD, SUB, SLT, NOR) in one registered cycle. It adds iterative unsigned multiply and divide, which write dedicated HI/LO result registers. It sits in the execute stage behind a start/busy/done handshake, so the control unit can stall on multi-cycle operations.

## Interface
- WIDTH, default 32: operand, result, HI and LO width; must be ≥ 4.
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only on an edge where busy=0.
- operation  in  4  opcode, sampled on the accepting edge.
- in1  in  WIDTH  operand A, sampled on the accepting edge.
- in2  in  WIDTH  operand B, sampled on the accepting edge.
- out  out  WIDTH  registered result; held until the next accepted op.
- zero  out  1  registered; 1 iff out == 0.
- busy  out  1  high while a MULTU/DIVU iteration is in progress.
- done  out  1  one-cycle pulse when out/zero (and HI/LO) are updated.
- hi  out  WIDTH  HI register: product upper half, or remainder.
- lo  out  WIDTH  LO register: product lower half, or quotient.

## Operation
Opcodes:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0110 SUB
- 0111 SLT: signed compare; out = 1 if in1 < in2, else 0.
- 1100 NOR
- 1000 MULTU
- 1001 DIVU
- Any other code: out = 0, zero = 1, done pulses; HI/LO unchanged.

Arithmetic and handshake rules:
- ADD and SUB wrap modulo 2^WIDTH. There is no overflow flag and no trap.
- zero is valid for every opcode, not only SUB.
- Acceptance: start=1 and state IDLE on a rising edge. A start while busy=1 is ignored and is not queued.

FSM states: IDLE, MUL, DIV.
- IDLE, single-cycle op accepted: out, zero and done update on the same edge; stay in IDLE.
- IDLE, MULTU accepted: load the multiplicand, the multiplier and a 2·WIDTH accumulator cleared to 0; set count = WIDTH; go to MUL.
- IDLE, DIVU accepted: load the dividend and divisor, clear the WIDTH+1-bit partial remainder, set count = WIDTH; go to DIV.
- MUL: shift-add one multiplier bit per edge and decrement count. On the edge where count reaches 0: {hi,lo} ← product, out ← lo, zero ← (lo == 0), done ← 1, go to IDLE.
- DIV: restoring division, one quotient bit per edge. Completion is the same as MUL, with lo ← quotient and hi ← remainder.
- Divide by zero uses no special path. With WIDTH iterations of restoring division it yields lo = all ones and hi = in1, at the normal latency.

## Timing
Reset values: out = 0, zero = 1, busy = 0, done = 0, hi = 0, lo = 0; state IDLE.

Latency is measured from accepting edge E0:
- Single-cycle ops: result and done=1 are visible in the cycle after E0.
- MULTU/DIVU: busy=1 in the cycles following E0 through edge E_WIDTH (WIDTH cycles). Results and done=1 are visible after E_WIDTH, when busy returns to 0.
- done is high for exactly one cycle per accepted op.

Back-to-back and hold rules:
- A start during the done=1 cycle is accepted, since the FSM is already in IDLE. A single-cycle op can issue every cycle.
- out and zero hold while busy=1; they are not updated mid-iteration.

Reset rules:
- reset dominates start.
- reset during MUL/DIV aborts the op. In the next cycle busy=0, done=0, hi=lo=0, and no done pulse is ever produced for the aborted op.

## Test plan
- WIDTH=32; ADD 10+5, then SUB 5−5, back-to-back → out=15, zero=0 after the first edge; out=0, zero=1 after the second; done high both cycles.
- SLT in1=0xFFFFFFFF, in2=1 → out=1. NOR 0,0 → out=0xFFFFFFFF, zero=0. Opcode 0011 → out=0, zero=1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - busy high for exactly 32 cycles.
  - Then hi=0xFFFFFFFE, lo=0x00000001, out=1, single done pulse.
  - A start with ADD issued mid-operation is ignored.
- DIVU 100 ÷ 7 → lo=14, hi=2, after 32 busy cycles.
- DIVU 9 ÷ 0 → lo=0xFFFFFFFF, hi=9, same latency.
- MULTU started, reset asserted at busy cycle 10 → next cycle busy=0, hi=lo=0, out=0, zero=1; no done in the following 40 cycles.
- WIDTH=8; MULTU 200 × 3 → hi=0x02, lo=0x58, after 8 busy cycles.
